// File: rtl/cnn_pkg.sv
// Shared types for the CNN convolution blocks: FSM state encoding and result-width helper.
package cnn_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DRAIN   = 3'd2,
    S_COMPUTE = 3'd3,
    S_OUTPUT  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Product of two DATA_WIDTH values plus growth for K*K accumulations.
  function automatic int res_w(input int data_width, input int kernel_size);
    return 2 * data_width + $clog2(kernel_size * kernel_size);
  endfunction

endpackage

// File: rtl/conv_ctrl_mac.sv
// Combinational KxK multiply-accumulate: unsigned pixels times signed weights, full-width signed sum.
module mac import cnn_pkg::*; #(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 8,
  localparam int RES_W      = res_w(DATA_WIDTH, KERNEL_SIZE)
) (
  input  logic        [DATA_WIDTH-1:0] i_window [KERNEL_SIZE][KERNEL_SIZE],
  input  logic signed [DATA_WIDTH-1:0] i_kernel [KERNEL_SIZE][KERNEL_SIZE],
  output logic signed [RES_W-1:0]      o_sum
);

  // Pixels zero-extend, weights sign-extend; the true sum always fits RES_W.
  always_comb begin
    o_sum = '0;
    for (int y = 0; y < KERNEL_SIZE; y++) begin
      for (int x = 0; x < KERNEL_SIZE; x++) begin
        o_sum = o_sum
              + $signed({{(RES_W-DATA_WIDTH){1'b0}}, i_window[y][x]})
              * $signed({{(RES_W-DATA_WIDTH){i_kernel[y][x][DATA_WIDTH-1]}}, i_kernel[y][x]});
      end
    end
  end

endmodule

// File: rtl/conv_ctrl.sv
// Convolution controller: fetches each KxK window from feature memory, MACs it, streams results.
// Optional macro CONV_CTRL_RELU_EN clamps negative results to zero.
module conv_ctrl import cnn_pkg::*; #(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8,
  localparam int RES_W      = res_w(DATA_WIDTH, KERNEL_SIZE),
  localparam int AW         = $clog2(IMG_W * IMG_H),
  localparam int RW         = $clog2(IMG_H),
  localparam int CW         = $clog2(IMG_W)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [DATA_WIDTH-1:0] kernel [KERNEL_SIZE][KERNEL_SIZE],
  output logic                         fm_rd_en,
  output logic        [AW-1:0]         fm_addr,
  input  logic        [DATA_WIDTH-1:0] fm_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [RES_W-1:0]      out_data,
  output logic        [RW-1:0]         out_row,
  output logic        [CW-1:0]         out_col,
  output logic                         busy,
  output logic                         done,
  output state_t                       o_dbg_state
);

  localparam int KW = $clog2(KERNEL_SIZE);
  localparam int KL = KERNEL_SIZE - 1;

  if (KERNEL_SIZE != 3 && KERNEL_SIZE != 5) begin : g_bad_kernel
    $error("conv_ctrl: KERNEL_SIZE must be 3 or 5");
  end
  if (IMG_W < KERNEL_SIZE) begin : g_bad_width
    $error("conv_ctrl: IMG_W must be >= KERNEL_SIZE");
  end
  if (IMG_H < KERNEL_SIZE) begin : g_bad_height
    $error("conv_ctrl: IMG_H must be >= KERNEL_SIZE");
  end

  state_t                  r_state, w_next;
  logic [RW-1:0]           r_row, r_out_row;
  logic [CW-1:0]           r_col, r_out_col;
  logic [KW-1:0]           r_ky, r_kx, r_wr_ky, r_wr_kx;
  logic                    r_wr_en;
  logic [DATA_WIDTH-1:0]   r_window [KERNEL_SIZE][KERNEL_SIZE];
  logic signed [RES_W-1:0] r_out_data, w_sum;
  logic                    w_fetch_last, w_last_col, w_last_row;

  assign w_fetch_last = (r_ky == KW'(KL)) && (r_kx == KW'(KL));
  assign w_last_col   = (r_col == CW'(IMG_W - KERNEL_SIZE));
  assign w_last_row   = (r_row == RW'(IMG_H - KERNEL_SIZE));

  assign out_data    = r_out_data;
  assign out_row     = r_out_row;
  assign out_col     = r_out_col;
  assign o_dbg_state = r_state;

  // Handshake: a result transfers on a rising edge where out_valid and out_ready are both 1;
  // out_valid stays high and the result stays frozen until then.
  always_comb begin
    w_next    = r_state;
    fm_rd_en  = 1'b0;
    fm_addr   = '0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        fm_rd_en = 1'b1;
        fm_addr  = AW'((32'(r_row) + 32'(r_ky)) * IMG_W + 32'(r_col) + 32'(r_kx));
        if (w_fetch_last) w_next = S_DRAIN;
      end
      S_DRAIN:   w_next = S_COMPUTE;
      S_COMPUTE: w_next = S_OUTPUT;
      S_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = (w_last_col && w_last_row) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_ky       <= '0;
      r_kx       <= '0;
      r_wr_ky    <= '0;
      r_wr_kx    <= '0;
      r_wr_en    <= 1'b0;
      r_out_data <= '0;
      r_out_row  <= '0;
      r_out_col  <= '0;
      for (int y = 0; y < KERNEL_SIZE; y++) begin
        for (int x = 0; x < KERNEL_SIZE; x++) begin
          r_window[y][x] <= '0;
        end
      end
    end else begin
      r_state <= w_next;
      // Read data returns one cycle later, so the write pointer trails the fetch pointer.
      r_wr_en <= (r_state == S_FETCH);
      r_wr_ky <= r_ky;
      r_wr_kx <= r_kx;
      if (r_wr_en) r_window[r_wr_ky][r_wr_kx] <= fm_rdata;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row <= '0;
            r_col <= '0;
            r_ky  <= '0;
            r_kx  <= '0;
          end
        end
        S_FETCH: begin
          if (r_kx == KW'(KL)) begin
            r_kx <= '0;
            r_ky <= (r_ky == KW'(KL)) ? '0 : r_ky + KW'(1);
          end else begin
            r_kx <= r_kx + KW'(1);
          end
        end
        S_COMPUTE: begin
`ifdef CONV_CTRL_RELU_EN
          r_out_data <= w_sum[RES_W-1] ? '0 : w_sum;
`else
          r_out_data <= w_sum;
`endif
          r_out_row <= r_row;
          r_out_col <= r_col;
        end
        S_OUTPUT: begin
          if (out_ready) begin
            if (w_last_col && w_last_row) begin
              r_row <= '0;
              r_col <= '0;
            end else if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + RW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  mac #(
    .KERNEL_SIZE (KERNEL_SIZE),
    .DATA_WIDTH  (DATA_WIDTH)
  ) u_mac (
    .i_window (r_window),
    .i_kernel (kernel),
    .o_sum    (w_sum)
  );

endmodule
